// File: rtl/mips_lsu_pkg.sv
// -----------------------------------------------------------------------------
// mips_lsu_pkg
// Shared definitions for the MIPS load/store unit: request op field positions,
// access size encodings, the FSM state type and lane masks used when
// extracting or merging sub-word data.
// -----------------------------------------------------------------------------
package mips_lsu_pkg;

    // Bit positions inside req_op.
    localparam int OP_STORE_BIT    = 3;
    localparam int OP_UNSIGNED_BIT = 2;

    // req_op[1:0] size encodings.
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Right-justified lane masks; shifted into position by the aligner.
    localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;

    // Natural-alignment check for a request of the given size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = |offset;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane steering for the load/store unit. All byte-order
// dependent logic lives here.
//   Build option: LSU_BIG_ENDIAN_EN -- defined selects MIPS big-endian lanes
//   (byte k at [31-8k:24-8k], half 0 at [31:16]); undefined selects
//   little-endian lanes (byte k at [8k+7:8k], half 0 at [15:0]).
// Ports:
//   word        in  32  memory word (read buffer)
//   offset      in   2  byte offset inside the word
//   size        in   2  access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   is_unsigned in   1  zero-extend instead of sign-extend on loads
//   store_data  in  32  right-justified store data
//   load_value  out 32  extracted and extended load result
//   store_word  out 32  word with the addressed lane replaced by store_data
// -----------------------------------------------------------------------------
module lsu_lane_align
    import mips_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] store_word
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [4:0]  shift;
    logic [31:0] mask;
    logic [31:0] lane;

    always_comb begin
`ifdef LSU_BIG_ENDIAN_EN
        byte_shift = {~offset, 3'b000};
        half_shift = {~offset[1], 4'b0000};
`else
        byte_shift = {offset, 3'b000};
        half_shift = {offset[1], 4'b0000};
`endif
        shift = (size == SZ_HALF) ? half_shift : byte_shift;
        mask  = (size == SZ_HALF) ? LANE_MASK_HALF : LANE_MASK_BYTE;
        lane  = (word >> shift) & mask;

        case (size)
            SZ_BYTE: load_value = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
            SZ_HALF: load_value = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
            default: load_value = word;
        endcase

        if (size == SZ_WORD) begin
            store_word = store_data;
        end else begin
            store_word = (word & ~(mask << shift)) | ((store_data & mask) << shift);
        end
    end

endmodule

// File: rtl/mips_load_store_unit.sv
// -----------------------------------------------------------------------------
// mips_load_store_unit
// Datapath-side initiator for a single-port, word-addressed data memory with
// combinational read and posedge write. Handles one request at a time; byte
// and halfword stores are done as read-modify-write because the memory only
// writes whole words.
//   Build option: LSU_BIG_ENDIAN_EN (lane order, see lsu_lane_align).
// Ports:
//   Clk, Reset_n                      clock, async active-low reset
//   req_valid/req_ready               request handshake
//   req_op[3:0]                       [3]=store [2]=unsigned [1:0]=size
//   req_addr, req_wdata               byte address, right-justified store data
//   resp_valid, resp_rdata, resp_err  one-cycle response
//   MemRead, MemWrite, address,       memory interface (address word aligned)
//   writeData, readData
//   state_dbg[1:0]                    current FSM state for observation
// Handshake: a request is taken on a clock edge where req_valid & req_ready;
// req_ready is high only in IDLE. resp_valid is a single-cycle pulse with no
// backpressure.
// -----------------------------------------------------------------------------
module mips_load_store_unit
    import mips_lsu_pkg::*;
#(
    parameter int MEM_DEPTH_LOG2 = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] address,
    output logic [31:0] writeData,
    input  logic [31:0] readData,
    output logic [1:0]  state_dbg
);

    lsu_state_t  state;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rbuf;
    logic        err_q;

    logic        req_bad;
    logic        req_out_of_range;
    logic        req_is_sw;
    logic [31:0] load_value;
    logic [31:0] store_word;

    // Request classification, evaluated only while IDLE.
    always_comb begin
        req_out_of_range = |(req_addr >> (MEM_DEPTH_LOG2 + 2));
        req_bad          = (req_op[1:0] == SZ_ILLEGAL)
                         | is_misaligned(req_op[1:0], req_addr[1:0])
                         | req_out_of_range;
        req_is_sw        = req_op[OP_STORE_BIT] & (req_op[1:0] == SZ_WORD);
    end

    lsu_lane_align u_align (
        .word        (rbuf),
        .offset      (addr_q[1:0]),
        .size        (op_q[1:0]),
        .is_unsigned (op_q[OP_UNSIGNED_BIT]),
        .store_data  (wdata_q),
        .load_value  (load_value),
        .store_word  (store_word)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rbuf    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_bad;
                        if (req_bad)        state <= RESP;
                        else if (req_is_sw) state <= WRITE;
                        else                state <= READ;
                    end
                end
                READ: begin
                    rbuf  <= readData;
                    // Sub-word stores need the old word before merging.
                    state <= op_q[OP_STORE_BIT] ? WRITE : RESP;
                end
                WRITE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state/latches only, so a reset drops
    // MemWrite immediately and nothing glitches with request inputs.
    always_comb begin
        req_ready  = (state == IDLE);
        MemRead    = (state == READ);
        MemWrite   = (state == WRITE);
        address    = (MemRead | MemWrite) ? {addr_q[31:2], 2'b00} : 32'd0;
        writeData  = MemWrite ? store_word : 32'd0;
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) & err_q;
        resp_rdata = ((state == RESP) & ~err_q & ~op_q[OP_STORE_BIT]) ? load_value : 32'd0;
        state_dbg  = state;
    end

endmodule

// File: tb/tb_mips_load_store_unit.sv
module tb_mips_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic [1:0]  state_dbg;

    always #5 Clk = ~Clk;

    mips_load_store_unit #(.MEM_DEPTH_LOG2(8)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData),
        .state_dbg  (state_dbg)
    );

    // Reference memory: byte addressable, 1 KiB.
    logic [7:0]  ref_bytes [0:1023];
    // Environment memory seen by the DUT: word addressed.
    logic [31:0] env_mem [0:255];
    logic        load_mem = 1'b0;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] ref_word(input int w);
`ifdef LSU_BIG_ENDIAN_EN
        return {ref_bytes[4*w], ref_bytes[4*w+1], ref_bytes[4*w+2], ref_bytes[4*w+3]};
`else
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
`endif
    endfunction

    task automatic set_ref_word(input int w, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
`ifdef LSU_BIG_ENDIAN_EN
            ref_bytes[4*w+i] = v[8*(3-i) +: 8];
`else
            ref_bytes[4*w+i] = v[8*i +: 8];
`endif
        end
    endtask

    assign readData = env_mem[address[9:2]];

    always @(posedge Clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= ref_word(i);
        end else if (MemWrite) begin
            env_mem[address[9:2]] <= writeData;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural model: byte-level memory, size in bytes, arithmetic extension.
    task automatic model_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] e_rd, output logic e_er, output int e_lat,
                                output int e_nrd, output int e_nwr);
        int          n;
        logic [63:0] v;
        logic        bad;
        n   = 1 << op[1:0];
        bad = (op[1:0] == 2'd3) || (op[1:0] == 2'd1 && (a % 2) != 0) ||
              (op[1:0] == 2'd2 && (a % 4) != 0) || (a >= 32'd1024);
        e_rd = 32'd0; e_er = 1'b0; e_lat = 0; e_nrd = 0; e_nwr = 0;
        if (bad) begin
            e_er = 1'b1; e_lat = 1;
        end else if (!op[3]) begin
            v = 64'd0;
            for (int i = 0; i < n; i++) begin
`ifdef LSU_BIG_ENDIAN_EN
                v = (v << 8) | 64'(ref_bytes[a+i]);
`else
                v = v | (64'(ref_bytes[a+i]) << (8*i));
`endif
            end
            if (!op[2] && v[8*n-1]) v = v - (64'd1 << (8*n));
            e_rd = v[31:0]; e_lat = 2; e_nrd = 1;
        end else begin
            for (int i = 0; i < n; i++) begin
`ifdef LSU_BIG_ENDIAN_EN
                ref_bytes[a+i] = wd[8*(n-1-i) +: 8];
`else
                ref_bytes[a+i] = wd[8*i +: 8];
`endif
            end
            e_lat = (n == 4) ? 2 : 3;
            e_nrd = (n == 4) ? 0 : 1;
            e_nwr = 1;
        end
    endtask

    // Called at posedge+1; returns at the negedge of the response cycle.
    task automatic do_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int n_rd, output int n_wr, output logic [31:0] wr_data);
        int guard;
        rd = 32'd0; er = 1'b0; lat = -1; n_rd = 0; n_wr = 0; wr_data = 32'd0;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(posedge Clk); #1; guard++;
        end
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk);
            if (MemRead) n_rd++;
            if (MemWrite) begin
                n_wr++;
                wr_data = writeData;
            end
            check("rd_wr_exclusive", {31'd0, MemRead & MemWrite}, 32'd0);
            check("addr_word_aligned", {30'd0, address[1:0]}, 32'd0);
            if (resp_valid) begin
                lat = c;
                rd  = resp_rdata;
                er  = resp_err;
                check("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
                break;
            end
        end
    endtask

    task automatic run_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] got_rd, output logic [31:0] got_wr);
        logic [31:0] e_rd;
        logic        e_er;
        int          e_lat, e_nrd, e_nwr;
        logic        er;
        int          lat, nrd, nwr;
        model_access(op, a, wd, e_rd, e_er, e_lat, e_nrd, e_nwr);
        do_req(op, a, wd, got_rd, er, lat, nrd, nwr, got_wr);
        check($sformatf("rdata op=%h addr=%h", op, a), got_rd, e_rd);
        check($sformatf("err op=%h addr=%h", op, a), {31'd0, er}, {31'd0, e_er});
        check($sformatf("latency op=%h addr=%h", op, a), lat, e_lat);
        check($sformatf("mem_reads op=%h addr=%h", op, a), nrd, e_nrd);
        check($sformatf("mem_writes op=%h addr=%h", op, a), nwr, e_nwr);
    endtask

    initial begin
        logic [31:0] rd, wr;
        logic [31:0] e_rd;
        logic        e_er;
        int          e_lat, e_nrd, e_nwr;
        logic [3:0]  op;
        logic [31:0] a, wd;
        int          guard;
        logic        saw_write;

        Reset_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int j = 0; j < 1024; j++) ref_bytes[j] = 8'($urandom_range(0, 255));
        set_ref_word(4, 32'h8899AABB);
        load_mem = 1'b1;
        repeat (2) @(posedge Clk);
        #1 load_mem = 1'b0;

        // Reset values.
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_memread", {31'd0, MemRead}, 32'd0);
        check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        check("rst_address", address, 32'd0);
        check("rst_writedata", writeData, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Directed loads on word 4.
        run_req(4'b0000, 32'h10, 32'd0, rd, wr);
`ifdef LSU_BIG_ENDIAN_EN
        check("tp_lb_be", rd, 32'hFFFFFF88);
`else
        check("tp_lb", rd, 32'hFFFFFFBB);
`endif
        run_req(4'b0100, 32'h13, 32'd0, rd, wr);
`ifndef LSU_BIG_ENDIAN_EN
        check("tp_lbu", rd, 32'h00000088);
`endif
        run_req(4'b0001, 32'h12, 32'd0, rd, wr);
`ifndef LSU_BIG_ENDIAN_EN
        check("tp_lh", rd, 32'hFFFF8899);
`endif
        run_req(4'b0101, 32'h10, 32'd0, rd, wr);
`ifndef LSU_BIG_ENDIAN_EN
        check("tp_lhu", rd, 32'h0000AABB);
`endif
        run_req(4'b0010, 32'h10, 32'd0, rd, wr);
        check("tp_lw", rd, 32'h8899AABB);

        // Sub-word stores (read-modify-write), then restore word 4.
        run_req(4'b1000, 32'h11, 32'h123456CC, rd, wr);
`ifndef LSU_BIG_ENDIAN_EN
        check("tp_sb_wdata", wr, 32'h8899CCBB);
        run_req(4'b0010, 32'h10, 32'd0, rd, wr);
        check("tp_lw_after_sb", rd, 32'h8899CCBB);
`endif
        run_req(4'b1010, 32'h10, 32'h8899AABB, rd, wr);
        check("tp_sw_wdata", wr, 32'h8899AABB);
        run_req(4'b1000, 32'h13, 32'h00000077, rd, wr);
`ifdef LSU_BIG_ENDIAN_EN
        check("tp_sb_be_wdata", wr, 32'h8899AA77);
`else
        check("tp_sb13_wdata", wr, 32'h7799AABB);
`endif
        run_req(4'b1010, 32'h10, 32'h8899AABB, rd, wr);

        // Error cases.
        run_req(4'b0010, 32'h12, 32'd0, rd, wr);
        run_req(4'b1001, 32'h11, 32'h5566, rd, wr);
        run_req(4'b0010, 32'h400, 32'd0, rd, wr);
        run_req(4'b0011, 32'h10, 32'd0, rd, wr);

        // Reset asserted during the WRITE cycle of an SH.
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(posedge Clk); #1; guard++;
        end
        req_valid = 1'b1; req_op = 4'b1001; req_addr = 32'h12; req_wdata = 32'h5566;
        @(posedge Clk); #1;
        req_valid = 1'b0;
        saw_write = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            check("sh_no_resp_before_reset", {31'd0, resp_valid}, 32'd0);
            if (MemWrite) begin
                saw_write = 1'b1;
                break;
            end
        end
        check("sh_reached_write", {31'd0, saw_write}, 32'd1);
        Reset_n = 1'b0;
        #1;
        check("mid_rst_memwrite", {31'd0, MemWrite}, 32'd0);
        check("mid_rst_memread", {31'd0, MemRead}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_address", address, 32'd0);
        check("mid_rst_writedata", writeData, 32'd0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            check("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        @(posedge Clk); #1;
        run_req(4'b0010, 32'h10, 32'd0, rd, wr);
        check("tp_lw_after_reset", rd, 32'h8899AABB);

        // req_valid held high while busy: next request only taken from IDLE.
        @(posedge Clk); #1;
        model_access(4'b0010, 32'h10, 32'd0, e_rd, e_er, e_lat, e_nrd, e_nwr);
        req_valid = 1'b1; req_op = 4'b0010; req_addr = 32'h10; req_wdata = 32'd0;
        @(posedge Clk); #1;
        req_op = 4'b0011;
        @(negedge Clk);
        check("hold_c1_ready", {31'd0, req_ready}, 32'd0);
        check("hold_c1_memread", {31'd0, MemRead}, 32'd1);
        check("hold_c1_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge Clk);
        check("hold_c2_resp", {31'd0, resp_valid}, 32'd1);
        check("hold_c2_rdata", resp_rdata, e_rd);
        check("hold_c2_err", {31'd0, resp_err}, 32'd0);
        @(negedge Clk);
        check("hold_c3_ready", {31'd0, req_ready}, 32'd1);
        check("hold_c3_resp", {31'd0, resp_valid}, 32'd0);
        model_access(4'b0011, 32'h10, 32'd0, e_rd, e_er, e_lat, e_nrd, e_nwr);
        @(posedge Clk); #1;
        req_valid = 1'b0;
        @(negedge Clk);
        check("hold_c4_resp", {31'd0, resp_valid}, 32'd1);
        check("hold_c4_err", {31'd0, resp_err}, {31'd0, e_er});
        check("hold_c4_rdata", resp_rdata, e_rd);
        @(posedge Clk); #1;

        // Randomized traffic against the byte-level model.
        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 15));
            if (op[1:0] == 2'd3 && $urandom_range(0, 3) != 0) op[1:0] = 2'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (op[1:0] == 2'd1) a[0] = 1'b0;
                if (op[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(10, 31));
            wd = $urandom();
            run_req(op, a, wd, rd, wr);
        end

        // Final memory image against the model.
        @(posedge Clk); #1;
        for (int i = 0; i < 256; i++) begin
            check($sformatf("mem_word_%0d", i), env_mem[i], ref_word(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
